// File: rtl/demux_pkg.sv
// demux_pkg: shared width, channel count and channel select constants for the 1-to-4 demux
package demux_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int N_CH = 4;
  localparam logic [1:0] CH0 = 2'b00;
  localparam logic [1:0] CH1 = 2'b01;
  localparam logic [1:0] CH2 = 2'b10;
  localparam logic [1:0] CH3 = 2'b11;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry EMPTY/FULL buffer; code reads zero while empty
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_ready,
  input  logic [WIDTH-1:0] i_code,
  output logic [WIDTH-1:0] o_code,
  output logic             o_valid,
  output logic             o_free
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic             drain;
  assign drain = valid_q & i_ready;
  // a load on a draining edge keeps the slot full with the new code
  always_comb begin
    valid_d = i_load | (valid_q & ~drain);
    code_d  = i_load ? i_code : (drain ? '0 : code_q);
  end
  // state register; reset wins over load and drain
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end
  assign o_code  = code_q;
  assign o_valid = valid_q;
  assign o_free  = ~valid_q | i_ready;
endmodule

// File: rtl/demux_1_4_8_bit_reg.sv
// demux_1_4_8_bit_reg: 1-to-4 registered demux; DEMUX_XFER_CNT_EN adds o_xfer_cnt accept counter
module demux_1_4_8_bit_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_code,
  input  logic [1:0]       i_sel_code,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_code_0,
  output logic [WIDTH-1:0] o_code_1,
  output logic [WIDTH-1:0] o_code_2,
  output logic [WIDTH-1:0] o_code_3,
  output logic             o_valid_0,
  output logic             o_valid_1,
  output logic             o_valid_2,
  output logic             o_valid_3,
`ifdef DEMUX_XFER_CNT_EN
  output logic [15:0]      o_xfer_cnt,
`endif
  input  logic             i_ready_0,
  input  logic             i_ready_1,
  input  logic             i_ready_2,
  input  logic             i_ready_3
);
  logic [N_CH-1:0]  ready, free, valid, load;
  logic [WIDTH-1:0] code [N_CH];
  logic             accept;
  assign ready   = {i_ready_3, i_ready_2, i_ready_1, i_ready_0};
  assign o_ready = ~i_rst & i_en & free[i_sel_code];
  assign accept  = i_valid & o_ready;
  genvar g;
  for (g = 0; g < N_CH; g++) begin : g_slot
    assign load[g] = accept & (i_sel_code == 2'(g));
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (load[g]),
      .i_ready(ready[g]),
      .i_code (i_code),
      .o_code (code[g]),
      .o_valid(valid[g]),
      .o_free (free[g])
    );
  end
  assign o_code_0  = code[CH0];
  assign o_code_1  = code[CH1];
  assign o_code_2  = code[CH2];
  assign o_code_3  = code[CH3];
  assign o_valid_0 = valid[CH0];
  assign o_valid_1 = valid[CH1];
  assign o_valid_2 = valid[CH2];
  assign o_valid_3 = valid[CH3];
`ifdef DEMUX_XFER_CNT_EN
  logic [15:0] cnt_q;
  // accept counter, wraps naturally at 16 bits
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else if (accept) cnt_q <= cnt_q + 16'd1;
  end
  assign o_xfer_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_demux_1_4_8_bit_reg.sv
// tb_demux_1_4_8_bit_reg: directed checks of the 1-to-4 registered demux
module tb_demux_1_4_8_bit_reg;
  logic       clk = 1'b0;
  logic       rst, en, valid;
  logic [7:0] code;
  logic [1:0] sel;
  logic       rdy0, rdy1, rdy2, rdy3;
  logic       ready;
  logic [7:0] c0, c1, c2, c3;
  logic       v0, v1, v2, v3;
`ifdef DEMUX_XFER_CNT_EN
  logic [15:0] cnt;
`endif
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux_1_4_8_bit_reg dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_code(code), .i_sel_code(sel),
    .i_valid(valid), .o_ready(ready),
    .o_code_0(c0), .o_code_1(c1), .o_code_2(c2), .o_code_3(c3),
    .o_valid_0(v0), .o_valid_1(v1), .o_valid_2(v2), .o_valid_3(v3),
`ifdef DEMUX_XFER_CNT_EN
    .o_xfer_cnt(cnt),
`endif
    .i_ready_0(rdy0), .i_ready_1(rdy1), .i_ready_2(rdy2), .i_ready_3(rdy3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; valid = 1'b1; code = 8'hEE; sel = 2'd0;
    {rdy3, rdy2, rdy1, rdy0} = 4'hF;
    #1;
    chk("ready_in_reset", 32'(ready), 32'd0);
    tick(); tick();
    chk("reset_valids", 32'({v3, v2, v1, v0}), 32'h0);
    chk("reset_codes", {c3, c2, c1, c0}, 32'h0);
    // single transfer
    rst = 1'b0; sel = 2'd2; code = 8'hA5; #1;
    chk("single_ready", 32'(ready), 32'd1);
    tick(); valid = 1'b0;
    chk("single_valids", 32'({v3, v2, v1, v0}), 32'b0100);
    chk("single_code2", 32'(c2), 32'hA5);
    tick();
    chk("single_gone", 32'({v3, v2, v1, v0}), 32'h0);
    chk("single_code2_zero", 32'(c2), 32'h0);
    // backpressure on ch1
    rdy1 = 1'b0; sel = 2'd1; code = 8'h11; valid = 1'b1;
    tick();
    chk("bp_held_valid", 32'({v3, v2, v1, v0}), 32'b0010);
    chk("bp_held_code", 32'(c1), 32'h11);
    code = 8'h22; #1;
    chk("bp_stall_ready", 32'(ready), 32'd0);
    tick();
    chk("bp_still_11", 32'(c1), 32'h11);
    chk("bp_still_stall", 32'(ready), 32'd0);
    rdy1 = 1'b1; #1;
    chk("bp_ready_release", 32'(ready), 32'd1);
    tick(); valid = 1'b0;
    chk("bp_reload_valid", 32'(v1), 32'd1);
    chk("bp_reload_code", 32'(c1), 32'h22);
    tick();
    chk("bp_drained", 32'({v1, c1}), 32'h0);
    // independence: ch0 stalled, ch3 free
    rdy0 = 1'b0; sel = 2'd0; code = 8'h5A; valid = 1'b1;
    tick();
    chk("ind_ch0_ready", 32'(ready), 32'd0);
    sel = 2'd3; code = 8'h3C; #1;
    chk("ind_resel_ready", 32'(ready), 32'd1);
    tick(); valid = 1'b0;
    chk("ind_code3", 32'(c3), 32'h3C);
    chk("ind_code0", 32'(c0), 32'h5A);
    chk("ind_valids", 32'({v3, v2, v1, v0}), 32'b1001);
    tick();
    chk("ind_ch3_drained", 32'({v3, v2, v1, v0}), 32'b0001);
    // disable: no accepts, held code still drains
    en = 1'b0; valid = 1'b1; sel = 2'd1; code = 8'h77;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("dis_ready", 32'(ready), 32'd0);
      tick();
      chk("dis_valids", 32'({v3, v2, v1, v0}), 32'b0001);
    end
    rdy0 = 1'b1;
    tick();
    chk("dis_drain", 32'({v3, v2, v1, v0}), 32'h0);
    // reset mid-operation with all channels full
    en = 1'b1; {rdy3, rdy2, rdy1, rdy0} = 4'h0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i); code = 8'h10 + 8'(i);
      tick();
    end
    chk("full_valids", 32'({v3, v2, v1, v0}), 32'hF);
    chk("full_codes", {c3, c2, c1, c0}, 32'h13121110);
`ifdef DEMUX_XFER_CNT_EN
    chk("cnt_before_rst", 32'(cnt), 32'd9);
`endif
    rst = 1'b1; sel = 2'd0; code = 8'hFF; #1;
    chk("rst_ready", 32'(ready), 32'd0);
    tick(); rst = 1'b0; valid = 1'b0;
    chk("rst_valids", 32'({v3, v2, v1, v0}), 32'h0);
    chk("rst_codes", {c3, c2, c1, c0}, 32'h0);
`ifdef DEMUX_XFER_CNT_EN
    chk("rst_cnt", 32'(cnt), 32'd0);
    // counter wrap
    rdy0 = 1'b1; sel = 2'd0; valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      code = 8'(i);
      tick();
    end
    chk("cnt_ffff", 32'(cnt), 32'hFFFF);
    tick(); tick(); valid = 1'b0;
    chk("cnt_wrap", 32'(cnt), 32'h0001);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
